// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
// The leading-zero helper is used only when SEG7_LZ_BLANK_EN is defined.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_code_t;
  typedef seg_code_t [NUM_DIGITS-1:0] seg_bank_t;

  localparam seg_code_t SEG_OFF   = 7'b0000000;
  localparam seg_code_t ZERO_CODE = 7'b0111111;

  // Blank leading zero digits from the most significant digit down.
  // A set decimal point or a non-zero digit ends the run; digit0 always shows.
  function automatic seg_bank_t lz_suppress(input seg_bank_t codes,
                                            input logic [NUM_DIGITS-1:0] dpm);
    seg_bank_t res;
    logic      scanning;
    res      = codes;
    scanning = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (scanning && (codes[i] == ZERO_CODE) && !dpm[i]) begin
        res[i] = SEG_OFF;
      end else begin
        scanning = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot prescaler and digit index counter for the scan driver.
// Produces the current digit index, the dead-time gate and frame boundary strobes.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 10_000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk0,
  input  logic       reset_sw,
  output logic [1:0] idx,
  output logic       slot_active,
  output logic       frame_end,
  output logic       frame_start
);

  localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt;
  logic             slot_end;

  assign slot_end    = (cnt == CNT_LAST);
  assign slot_active = (cnt >= CNT_BLANK);
  assign frame_end   = slot_end && (idx == 2'(NUM_DIGITS - 1));
  assign frame_start = (cnt == '0) && (idx == 2'd0);

  always_ff @(posedge clk0 or posedge reset_sw) begin
    if (reset_sw) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with dead-time and per-frame snapshot.
// Define SEG7_LZ_BLANK_EN to enable leading-zero suppression at snapshot time.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int   SCAN_DIV     = 10_000,
  parameter int   BLANK_CYC    = 500,
  parameter logic LINE_ACT_LOW = 1'b1,
  parameter logic SEG_ACT_LOW  = 1'b0
) (
  input  logic                    clk0,
  input  logic                    reset_sw,
  input  logic [NUM_DIGITS*7-1:0] code_in,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   line,
  output logic                    frame_tick
);

  logic [1:0]            idx;
  logic                  slot_active;
  logic                  frame_end;
  logic                  frame_start;

  seg_bank_t             shadow;
  logic [NUM_DIGITS-1:0] shadow_dp;
  seg_bank_t             snap_codes;
  // Clear until the first snapshot lands, so the first frame after reset stays dark.
  logic                  primed;

  logic                  show;
  logic [NUM_DIGITS-1:0] line_nxt;
  seg_code_t             seg_nxt;
  logic                  dp_nxt;

  seg7_scan_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk0        (clk0),
    .reset_sw    (reset_sw),
    .idx         (idx),
    .slot_active (slot_active),
    .frame_end   (frame_end),
    .frame_start (frame_start)
  );

`ifdef SEG7_LZ_BLANK_EN
  assign snap_codes = lz_suppress(seg_bank_t'(code_in), dp_mask);
`else
  assign snap_codes = seg_bank_t'(code_in);
`endif

  always_comb begin
    show     = slot_active && primed;
    line_nxt = '0;
    seg_nxt  = SEG_OFF;
    dp_nxt   = 1'b0;
    if (show) begin
      line_nxt = NUM_DIGITS'(1) << idx;
      seg_nxt  = shadow[idx];
      dp_nxt   = shadow_dp[idx];
    end
  end

  always_ff @(posedge clk0 or posedge reset_sw) begin
    if (reset_sw) begin
      shadow     <= {NUM_DIGITS{SEG_OFF}};
      shadow_dp  <= '0;
      primed     <= 1'b0;
      seg        <= {7{SEG_ACT_LOW}};
      dp         <= SEG_ACT_LOW;
      line       <= {NUM_DIGITS{LINE_ACT_LOW}};
      frame_tick <= 1'b0;
    end else begin
      if (frame_end) begin
        shadow    <= snap_codes;
        shadow_dp <= dp_mask;
        primed    <= 1'b1;
      end
      frame_tick <= frame_start && primed;
      line       <= line_nxt ^ {NUM_DIGITS{LINE_ACT_LOW}};
      seg        <= seg_nxt ^ {7{SEG_ACT_LOW}};
      dp         <= dp_nxt ^ SEG_ACT_LOW;
    end
  end

endmodule
